seq_skew_gen: RTL
=================

SEQ_SKEW_GEN -- requirements
Module: seq_skew_gen

Interface
REQ-001 Parameter CHANNELS, default 4, number of skewed output lanes (1..16).
REQ-002 Parameter WIDTH, default 8, data bits per lane.
REQ-003 Parameter LEN_W, default 8, width of sequence length field.
REQ-004 Parameter STEP, default 16, per-lane data offset added to base.
REQ-005 Port clock  input  1  single clock; all state changes on posedge clock.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port start  input  1  request to launch a sequence; sampled on posedge clock.
REQ-008 Port len  input  LEN_W  number of elements each lane emits; captured at start acceptance.
REQ-009 Port base  input  WIDTH  start value; captured at start acceptance.
REQ-010 Port ready  input  1  downstream advance enable; 0 freezes the sequence.
REQ-011 Port busy  output  1  high while in RUN.
REQ-012 Port done  output  1  one-cycle completion pulse.
REQ-013 Port valid  output  CHANNELS  per-lane valid, bit c = lane c.
REQ-014 Port data  output  CHANNELS*WIDTH  per-lane data, lane c in bits [c*WIDTH +: WIDTH].

Function
REQ-015 FSM states IDLE, RUN, DONE; internal step counter t, width LEN_W+5 bits (sufficient for len+CHANNELS-1).
REQ-016 start accepted only when busy=0 (state IDLE or DONE); start while in RUN ignored, no effect on state or captured values.
REQ-017 On acceptance with len>0: next state RUN, t=0, len/base registered.
REQ-018 On acceptance with len=0: next state DONE, no valid asserted at any cycle.
REQ-019 In RUN: valid[c] = (t >= c) and (t < c+len), combinational from registered t/len.
REQ-020 Lane c data while valid[c]=1: base + (t-c) + c*STEP, truncated modulo 2^WIDTH (wrap, no saturation).
REQ-021 Lane data SHALL be 0 whenever valid[c]=0.
REQ-022 In RUN with ready=1: t increments by 1 per cycle; with ready=0: t, valid, data hold unchanged.
REQ-023 In RUN with ready=1 and t = len+CHANNELS-2: next state DONE (total len+CHANNELS-1 advancing cycles).
REQ-024 DONE lasts exactly one cycle: done=1, busy=0, valid=0; next state IDLE unless start accepted in that cycle (then REQ-017/018).
REQ-025 done SHALL be 0 in IDLE and RUN; busy SHALL be 1 only in RUN.
REQ-026 ready ignored outside RUN; ready=0 in last RUN cycle delays DONE until a ready=1 cycle.

Reset
REQ-027 reset_n=0 asynchronously forces state IDLE, t=0, captured len/base=0; busy, done, valid, data all 0 without waiting for a clock edge.
REQ-028 Reset asserted mid-RUN aborts the sequence; no done pulse is generated for it.
REQ-029 After reset_n deassertion, first start accepted on the first posedge with start=1.

Verification (CHANNELS=4, WIDTH=8, STEP=16)
REQ-030 len=3, base=0x10, ready=1: lane0 valid t=0..2 data 0x10,0x11,0x12; lane3 valid t=3..5 data 0x40,0x41,0x42; done pulses in 7th cycle after acceptance edge.
REQ-031 Same as REQ-030, ready=0 for two cycles at t=2: valid/data hold at t=2 values, done delayed by exactly 2 cycles.
REQ-032 len=3, base=0xFE: lane0 data 0xFE,0xFF,0x00; lane1 data 0x0E,0x0F,0x10 (wrap-around).
REQ-033 len=0: no valid bit ever set; done=1 in the cycle after acceptance; busy stays 0.
REQ-034 start pulsed at t=1 during RUN: ignored, sequence unchanged; reset_n low at t=2: all outputs 0 immediately, no done.
REQ-035 start held high in DONE cycle with len=2: back-to-back RUN entered next cycle, lane0 valid at t=0,1 with new base.

Source files
------------

// File: rtl/seq_skew_gen.sv
// seq_skew_gen
//   Launches a skewed multi-lane counting sequence. Lane c starts c cycles
//   after lane 0 and emits `len` consecutive values starting at
//   base + c*STEP. The sequence advances only while `ready` is high.
//
// Ports
//   clock    in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   launch request, accepted when not busy
//   len      in   elements per lane, captured on acceptance
//   base     in   start value, captured on acceptance
//   ready    in   advance enable while running
//   busy     out  high while a sequence runs
//   done     out  one-cycle completion pulse
//   valid    out  per-lane valid, bit c = lane c
//   data     out  per-lane data, lane c in [c*WIDTH +: WIDTH], zero when invalid
//
// State   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | stepping t from 0 to len+CHANNELS-2, lanes valid per skew
// S_DONE  | single-cycle completion pulse; a start here relaunches at once

module seq_skew_gen #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8,
   parameter int LEN_W    = 8,
   parameter int STEP     = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [LEN_W-1:0]          len,
   input  logic [WIDTH-1:0]          base,
   input  logic                      ready,
   output logic                      busy,
   output logic                      done,
   output logic [CHANNELS-1:0]       valid,
   output logic [CHANNELS*WIDTH-1:0] data
);

   // Wide enough for len + CHANNELS - 1 with CHANNELS up to 16.
   localparam int T_W = LEN_W + 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [T_W-1:0]     t_q, t_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [WIDTH-1:0]   base_q, base_d;

   logic               accept;
   logic [T_W-1:0]     last_t;

   assign accept = start && (state_q != S_RUN);

   // Only evaluated in S_RUN where len_q >= 1, so this never underflows.
   assign last_t = T_W'(len_q) + T_W'(CHANNELS) - T_W'(2);

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      len_d   = len_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               len_d   = len;
               base_d  = base;
               t_d     = '0;
               state_d = (len == '0) ? S_DONE : S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (ready) begin
               if (t_q == last_t) begin
                  state_d = S_DONE;
               end else begin
                  t_d = t_q + T_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         len_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         len_q   <= len_d;
         base_q  <= base_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);

   // Lane outputs decode directly from registered t/len so they respond to
   // reset without a clock edge and hold naturally while ready is low.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      localparam logic [T_W-1:0]   C_T = T_W'(c);
      localparam logic [WIDTH-1:0] OFS = WIDTH'(c * STEP);
      logic lane_vld;

      assign lane_vld = busy && (t_q >= C_T) && (t_q < C_T + T_W'(len_q));
      assign valid[c] = lane_vld;
      assign data[c*WIDTH +: WIDTH] =
         lane_vld ? (base_q + WIDTH'(t_q - C_T) + OFS) : '0;
   end

endmodule
